// File: rtl/mem_access_pkg.sv
// Shared types and constants for the CPU-to-memory access controller.
package mem_access_pkg;

  // Transaction sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Extra access cycles beyond the first when no override is given.
  localparam int WAIT_STATES_DEFAULT = 2;

  // Counter width covering wait-state values 0..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/ws_counter.sv
// Wait-state counter: clears to zero, counts up while enabled, and flags
// when the count has reached the configured terminal value.
module ws_counter #(
  parameter int TERMINAL = 2,
  parameter int W        = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [W-1:0] TC = W'(TERMINAL);

  logic [W-1:0] count_reg;

  // Count register: clear has priority over enable.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Terminal flag is a decode of the registered count only.
  assign terminal = (count_reg == TC);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: accepts a single read or write request from the
// CPU, drives the memory bus for WAIT_STATES+1 cycles, then pulses done.
// All outputs are registers, so nothing combinational reaches them from inputs.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        protocol_err,
  output logic [15:0] ADDR,
  output logic        OE,
  output logic        WE,
  output logic [15:0] Data_from_CPU,
  input  logic [15:0] Data_to_CPU
);

  state_t state_reg;
  logic   is_read_reg;
  logic   ws_clear;
  logic   ws_enable;
  logic   ws_terminal;

  // The counter sits at zero throughout IDLE, so every ACCESS starts from 0.
  assign ws_clear  = (state_reg == IDLE);
  assign ws_enable = (state_reg == ACCESS);

  ws_counter #(
    .TERMINAL (WAIT_STATES),
    .W        (CNT_W)
  ) u_ws_counter (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (ws_clear),
    .enable   (ws_enable),
    .terminal (ws_terminal)
  );

  // Sequencer with registered bus controls, status flags and MAR/MDR.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      is_read_reg   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      protocol_err  <= 1'b0;
      OE            <= 1'b0;
      WE            <= 1'b0;
      ADDR          <= 16'h0000;
      Data_from_CPU <= 16'h0000;
      rdata         <= 16'h0000;
    end else begin
      done         <= 1'b0;
      protocol_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_read ^ req_write) begin
            ADDR          <= addr_in;
            Data_from_CPU <= wdata_in;
            is_read_reg   <= req_read;
            OE            <= req_read;
            WE            <= req_write;
            busy          <= 1'b1;
            state_reg     <= ACCESS;
          end else if (req_read && req_write) begin
            // Conflicting request: flag it and start nothing.
            protocol_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (ws_terminal) begin
            OE        <= 1'b0;
            WE        <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
            if (is_read_reg) begin
              rdata <= Data_to_CPU;
            end
          end
        end
        DONE: begin
          // Requests seen here are dropped; the next one is taken in IDLE.
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          OE        <= 1'b0;
          WE        <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a WAIT_STATES=2 instance driven by
// a vector table plus hand sequences, and a WAIT_STATES=0 instance for
// back-to-back requests. Both instances share the input stimulus.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write;
  logic [15:0] addr_in, wdata_in, data_to_cpu;

  logic        a_busy, a_done, a_perr, a_oe, a_we;
  logic [15:0] a_rdata, a_addr, a_wdata;
  logic        b_busy, b_done, b_perr, b_oe, b_we;
  logic [15:0] b_rdata, b_addr, b_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_STATES(2)) dut_a (
    .Clk(clk), .Reset(reset), .req_read(req_read), .req_write(req_write),
    .addr_in(addr_in), .wdata_in(wdata_in), .busy(a_busy), .done(a_done),
    .rdata(a_rdata), .protocol_err(a_perr), .ADDR(a_addr), .OE(a_oe),
    .WE(a_we), .Data_from_CPU(a_wdata), .Data_to_CPU(data_to_cpu)
  );

  mem_access_ctrl #(.WAIT_STATES(0)) dut_b (
    .Clk(clk), .Reset(reset), .req_read(req_read), .req_write(req_write),
    .addr_in(addr_in), .wdata_in(wdata_in), .busy(b_busy), .done(b_done),
    .rdata(b_rdata), .protocol_err(b_perr), .ADDR(b_addr), .OE(b_oe),
    .WE(b_we), .Data_from_CPU(b_wdata), .Data_to_CPU(data_to_cpu)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] bus;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  // Control bundle {busy, done, OE, WE, protocol_err}
  function automatic logic [4:0] ctl_a();
    return {a_busy, a_done, a_oe, a_we, a_perr};
  endfunction

  function automatic logic [4:0] ctl_b();
    return {b_busy, b_done, b_oe, b_we, b_perr};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Advance one clock; sampling and driving happen 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_read = 0; req_write = 0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_ctl;
    int         dones;

    req_read = 0; req_write = 0; addr_in = 0; wdata_in = 0; data_to_cpu = 0;
    reset = 1'b1;

    // rd wr addr wdata bus exp_rdata
    vecs[0] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 16'h1234, 16'h5555, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 16'h0101, 16'h7777, 16'h6666, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 16'h0F0F};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'hA5A5, 16'h3333, 16'h0F0F};
    vecs[5] = '{1'b1, 1'b0, 16'h8001, 16'h9999, 16'h0000, 16'h0000};

    do_reset();
    chk("reset_ctl", {11'd0, ctl_a()}, 16'h0000);
    chk("reset_addr", a_addr, 16'h0000);
    chk("reset_wdata", a_wdata, 16'h0000);
    chk("reset_rdata", a_rdata, 16'h0000);
    $display("reset: checked state after reset");

    // Table-driven single transactions on the WAIT_STATES=2 instance.
    for (int v = 0; v < 6; v++) begin
      req_read    = vecs[v].rd;
      req_write   = vecs[v].wr;
      addr_in     = vecs[v].addr;
      wdata_in    = vecs[v].wdata;
      data_to_cpu = vecs[v].bus;
      step();
      req_read = 0; req_write = 0;
      for (int c = 1; c <= 5; c++) begin
        if (vecs[v].rd && vecs[v].wr)
          exp_ctl = (c == 1) ? 5'b00001 : 5'b00000;
        else if (c <= 3)
          exp_ctl = {1'b1, 1'b0, vecs[v].rd, vecs[v].wr, 1'b0};
        else if (c == 4)
          exp_ctl = 5'b11000;
        else
          exp_ctl = 5'b00000;
        chk($sformatf("v%0d_ctl_c%0d", v, c), {11'd0, ctl_a()}, {11'd0, exp_ctl});
        if (!(vecs[v].rd && vecs[v].wr) && (c == 1 || c == 4)) begin
          chk($sformatf("v%0d_addr_c%0d", v, c), a_addr, vecs[v].addr);
          chk($sformatf("v%0d_wdata_c%0d", v, c), a_wdata, vecs[v].wdata);
        end
        if (c >= 4) chk($sformatf("v%0d_rdata_c%0d", v, c), a_rdata, vecs[v].exp_rdata);
        if (c == 4) data_to_cpu = ~vecs[v].bus;  // rdata must hold afterwards
        step();
      end
      $display("vec %0d: rd=%0b wr=%0b addr=%h rdata=%h", v, vecs[v].rd, vecs[v].wr, a_addr, a_rdata);
    end

    // Reset during cycle 2 of a read aborts it with no done pulse.
    req_read = 1; addr_in = 16'h0030; data_to_cpu = 16'hBEEF;
    step();
    req_read = 0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_ctl", {11'd0, ctl_a()}, 16'h0000);
    chk("abort_rdata", a_rdata, 16'h0000);
    chk("abort_addr", a_addr, 16'h0000);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      if (a_done) dones++;
      step();
    end
    chk("abort_no_done", 16'(dones), 16'd0);
    $display("abort: reset mid-read, done pulses seen=%0d", dones);

    // Requests toggled while busy are ignored; one done per accepted request.
    do_reset();
    req_read = 1; addr_in = 16'h1111; data_to_cpu = 16'hCAFE;
    step();
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      req_read  = (c == 1 || c == 3);
      req_write = (c == 2);
      addr_in   = 16'h2222;
      if (c <= 4) chk($sformatf("toggle_addr_c%0d", c), a_addr, 16'h1111);
      if (a_done) dones++;
      step();
    end
    req_read = 0; req_write = 0;
    chk("toggle_done_count", 16'(dones), 16'd1);
    chk("toggle_rdata", a_rdata, 16'hCAFE);
    chk("toggle_no_err", {15'd0, a_perr}, 16'd0);
    $display("toggle: done pulses=%0d addr=%h", dones, a_addr);

    // WAIT_STATES=0 instance with req_read held high continuously.
    do_reset();
    req_read = 1; addr_in = 16'h00A0; data_to_cpu = 16'h1234;
    step();
    chk("b2b_c1_ctl", {11'd0, ctl_b()}, 16'(5'b10100));
    chk("b2b_c1_addr", b_addr, 16'h00A0);
    addr_in = 16'h00B0;
    step();
    chk("b2b_c2_ctl", {11'd0, ctl_b()}, 16'(5'b11000));
    chk("b2b_c2_rdata", b_rdata, 16'h1234);
    addr_in = 16'h00C0; data_to_cpu = 16'h5678;
    step();
    chk("b2b_c3_ctl", {11'd0, ctl_b()}, 16'h0000);
    chk("b2b_c3_addr", b_addr, 16'h00A0);
    addr_in = 16'h00D0;
    step();
    chk("b2b_c4_ctl", {11'd0, ctl_b()}, 16'(5'b10100));
    chk("b2b_c4_addr", b_addr, 16'h00D0);
    step();
    chk("b2b_c5_ctl", {11'd0, ctl_b()}, 16'(5'b11000));
    chk("b2b_c5_rdata", b_rdata, 16'h5678);
    req_read = 0;
    step();
    chk("b2b_c6_ctl", {11'd0, ctl_b()}, 16'h0000);
    $display("b2b: second addr=%h rdata=%h", b_addr, b_rdata);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
